// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter: accepts one word, emits it LSB first with a
// capture strobe every BIT_CYCLES clocks, then pulses done before re-arming.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shift_dn;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CYC_W-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic             strobe;

  // Right-shifted copy of the word with a zero entering at the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign shift_dn[gi] = 1'b0;
      end else begin : g_mid
        assign shift_dn[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      cyc_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      cyc_cnt_reg <= cyc_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    cyc_cnt_next = cyc_cnt_reg;
    load_ready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    strobe       = 1'b0;
    case (state_reg)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift_next   = data_in;
          bit_cnt_next = '0;
          cyc_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cyc_cnt_reg == LAST_CYC) begin
          // Downstream captures the current bit on this edge; advance to the next one.
          strobe       = 1'b1;
          cyc_cnt_next = '0;
          shift_next   = shift_dn;
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = DONE;
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ser_out = shift_reg[0];
  assign ser_en  = strobe;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the number of bits per word (legal range 2..32).
REQ-002 The module SHALL have parameter BIT_CYCLES, default 1, the number of Clock cycles per serial bit (legal range 1..16).
REQ-003 The module SHALL have port Clock  input  1  the single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The module SHALL have port load_valid  input  1  data_in holds a word to transmit.
REQ-006 The module SHALL have port load_ready  output  1  the block can accept a word this cycle.
REQ-007 The module SHALL have port data_in  input  WIDTH  parallel word, sampled only on acceptance.
REQ-008 The module SHALL have port ser_out  output  1  serial data bit, LSB first, intended for a downstream enabled DFF's D input.
REQ-009 The module SHALL have port ser_en  output  1  one-cycle strobe marking the Clock edge at which the downstream DFF captures ser_out.
REQ-010 The module SHALL have port busy  output  1  a word is being shifted.
REQ-011 The module SHALL have port done  output  1  one-cycle pulse after the last bit is strobed.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, load_ready SHALL be 1; in SHIFT and DONE, load_ready SHALL be 0.
REQ-014 Acceptance SHALL occur on a rising edge where load_valid=1 and load_ready=1; at that edge the block SHALL load data_in into the shift register, clear bit_cnt and cyc_cnt, and enter SHIFT.
REQ-015 load_valid SHALL be ignored while load_ready=0, and data_in SHALL NOT be sampled at any edge other than the acceptance edge.
REQ-016 ser_out SHALL equal shift-register bit 0 at all times, i.e. a registered value with no combinational path from inputs.
REQ-017 ser_en SHALL be 1 only when state=SHIFT and cyc_cnt=BIT_CYCLES-1, and SHALL be 0 otherwise.
REQ-018 In SHIFT, cyc_cnt SHALL increment on each edge and wrap to 0 on an edge where ser_en=1.
REQ-019 On an edge where ser_en=1, the block SHALL shift the register right by one (MSB filled with 0) and increment bit_cnt.
REQ-020 When ser_en=1 and bit_cnt=WIDTH-1, the next state SHALL be DONE.
REQ-021 busy SHALL be 1 exactly when state=SHIFT.
REQ-022 done SHALL be 1 exactly when state=DONE; DONE SHALL always advance to IDLE on the next edge.
REQ-023 Timing SHALL be as follows: acceptance at edge E; SHIFT occupies WIDTH*BIT_CYCLES cycles; done is high for cycle WIDTH*BIT_CYCLES+1 after E; load_ready returns one cycle later.
REQ-024 Counters SHALL be sized as bit_cnt = $clog2(WIDTH) bits and cyc_cnt = $clog2(BIT_CYCLES)+1 bits, with no overflow within legal parameter ranges.
REQ-025 When BIT_CYCLES=1, ser_en SHALL be high for every SHIFT cycle.
REQ-026 Any unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-027 While rst=0, independent of Clock, the block SHALL force state=IDLE, shift register=0, bit_cnt=0 and cyc_cnt=0, giving ser_out=0, ser_en=0, busy=0, done=0 and load_ready=1.
REQ-028 rst=0 asserted mid-SHIFT SHALL abort the word immediately with no done pulse, and no further ser_en SHALL occur.
REQ-029 After rst returns to 1, the first acceptance SHALL be possible at the next rising edge.

Verification
REQ-030 Bench SHALL check: WIDTH=8, BIT_CYCLES=1, load 8'hA5 -> ser_out at the 8 ser_en edges = 1,0,1,0,0,1,0,1; done high 1 cycle at cycle 9; load_ready high at cycle 10.
REQ-031 Bench SHALL check: BIT_CYCLES=3, load 8'h81 -> ser_en high every 3rd SHIFT cycle (8 strobes total), ser_out = 1,0,0,0,0,0,0,1 at strobes, busy high for 24 cycles.
REQ-032 Bench SHALL check: load_valid held high with 8'hFF then 8'h00 -> the second word is accepted only after done and load_ready, is not corrupted, and exactly 16 strobes occur.
REQ-033 Bench SHALL check: data_in changed and load_valid pulsed during SHIFT -> transmitted bits unchanged and no second acceptance occurs.
REQ-034 Bench SHALL check: rst=0 asserted between clock edges after the 3rd strobe -> all outputs reset immediately, no done pulse, and the next word transmits correctly after release.
REQ-035 Bench SHALL check: a downstream enabled DFF (D=ser_out, en=ser_en) -> its Q sequence matches the LSB-first word for 8'h3C.
